// File: rtl/dmem_access_ctrl_pkg.sv
// Shared encodings for the MEM-stage data-memory access controller:
// access sizes, controller states and the default bus timeout.
package dmem_access_ctrl_pkg;

   localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
   localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
   localparam logic [1:0] MEM_SIZE_WORD = 2'b10;

   localparam int DEFAULT_TIMEOUT = 255;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Little-endian lane steering: byte enables, store-data replication,
// load lane extraction with sign/zero extension, and alignment checking.
module dmem_lane_align
   import dmem_access_ctrl_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [1:0]        i_size,
   input  logic              i_unsigned,
   input  logic [1:0]        i_addrLsb,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [DATA_W-1:0] i_busRdata,
   output logic [3:0]        o_be,
   output logic [DATA_W-1:0] o_wdata,
   output logic [DATA_W-1:0] o_rdata,
   output logic              o_misaligned
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign w_byte = i_busRdata[{i_addrLsb, 3'b000} +: 8];
   assign w_half = i_addrLsb[1] ? i_busRdata[31:16] : i_busRdata[15:0];

   always_comb begin
      o_be         = 4'b0000;
      o_wdata      = '0;
      o_rdata      = '0;
      o_misaligned = 1'b0;
      case (i_size)
         MEM_SIZE_BYTE: begin
            o_be    = 4'b0001 << i_addrLsb;
            o_wdata = {4{i_wdata[7:0]}};
            o_rdata = {{24{~i_unsigned & w_byte[7]}}, w_byte};
         end
         MEM_SIZE_HALF: begin
            o_misaligned = i_addrLsb[0];
            o_be         = i_addrLsb[1] ? 4'b1100 : 4'b0011;
            o_wdata      = {2{i_wdata[15:0]}};
            o_rdata      = {{16{~i_unsigned & w_half[15]}}, w_half};
         end
         MEM_SIZE_WORD: begin
            o_misaligned = |i_addrLsb;
            o_be         = 4'b1111;
            o_wdata      = i_wdata;
            o_rdata      = i_busRdata;
         end
         default: begin
            o_misaligned = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory controller: turns a load/store request into a
// registered req/ack bus transaction and stalls the pipeline until it ends.
module dmem_access_ctrl
   import dmem_access_ctrl_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [1:0]        mem_size,
   input  logic              mem_unsigned,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic              mem_ready,
   output logic [DATA_W-1:0] rdata,
   output logic              misaligned,
   output logic              bus_err,
   output logic              bus_req,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [3:0]        bus_be,
   output logic [DATA_W-1:0] bus_wdata,
   input  logic              bus_ack,
   input  logic [DATA_W-1:0] bus_rdata
);

   localparam int               CNT_W   = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

   state_t              r_state;
   logic [CNT_W-1:0]    r_count;
   logic                r_busReq;
   logic                r_busWe;
   logic [ADDR_W-1:0]   r_busAddr;
   logic [3:0]          r_busBe;
   logic [DATA_W-1:0]   r_busWdata;
   logic [DATA_W-1:0]   r_rdata;
   logic                r_busErr;

   logic                w_access;
   logic                w_misaligned;
   logic                w_start;
   logic [3:0]          w_be;
   logic [DATA_W-1:0]   w_wdata;
   logic [DATA_W-1:0]   w_loadData;

   dmem_lane_align #(
      .DATA_W(DATA_W)
   ) u_laneAlign (
      .i_size      (mem_size),
      .i_unsigned  (mem_unsigned),
      .i_addrLsb   (addr[1:0]),
      .i_wdata     (wdata),
      .i_busRdata  (bus_rdata),
      .o_be        (w_be),
      .o_wdata     (w_wdata),
      .o_rdata     (w_loadData),
      .o_misaligned(w_misaligned)
   );

   assign w_access   = mem_read | mem_write;
   assign w_start    = (r_state == IDLE) && w_access && !w_misaligned;
   assign misaligned = w_access && w_misaligned;

   // A misaligned request completes immediately so the trap path can take it.
   assign mem_ready  = (r_state == DONE) || ((r_state == IDLE) && !w_start);

   assign rdata      = r_rdata;
   assign bus_err    = r_busErr;
   assign bus_req    = r_busReq;
   assign bus_we     = r_busWe;
   assign bus_addr   = r_busAddr;
   assign bus_be     = r_busBe;
   assign bus_wdata  = r_busWdata;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state    <= IDLE;
         r_count    <= '0;
         r_busReq   <= 1'b0;
         r_busWe    <= 1'b0;
         r_busAddr  <= '0;
         r_busBe    <= 4'b0000;
         r_busWdata <= '0;
         r_rdata    <= '0;
         r_busErr   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_start) begin
                  r_busReq   <= 1'b1;
                  r_busWe    <= mem_write;
                  r_busAddr  <= {addr[ADDR_W-1:2], 2'b00};
                  r_busBe    <= w_be;
                  r_busWdata <= w_wdata;
                  r_count    <= '0;
                  r_busErr   <= 1'b0;
                  r_state    <= REQ;
               end
            end
            REQ: begin
               r_count <= r_count + CNT_W'(1);
               // An ack on the final allowed cycle still wins over the timeout.
               if (bus_ack) begin
                  r_busReq <= 1'b0;
                  r_rdata  <= r_busWe ? '0 : w_loadData;
                  r_state  <= DONE;
               end else if (r_count == CNT_MAX) begin
                  r_busReq <= 1'b0;
                  r_busErr <= 1'b1;
                  r_rdata  <= '0;
                  r_state  <= DONE;
               end
            end
            DONE: begin
               r_count  <= '0;
               r_busErr <= 1'b0;
               r_state  <= IDLE;
            end
            default: begin
               r_busReq <= 1'b0;
               r_state  <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl: directed requests push expected
// responses; a monitor checks bus fields and completions as they appear.
module tb_dmem_access_ctrl;

   logic        clock;
   logic        reset;
   logic        mem_read;
   logic        mem_write;
   logic [1:0]  mem_size;
   logic        mem_unsigned;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        mem_ready;
   logic [31:0] rdata;
   logic        misaligned;
   logic        bus_err;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_ack;
   logic [31:0] bus_rdata;

   typedef struct {
      int          lowCycles;
      int          reqCycles;
      logic [31:0] addr;
      logic [3:0]  be;
      logic        we;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        err;
      logic        mis;
   } exp_t;

   exp_t        expQ[$];
   int          vectors = 0;
   int          miscompares = 0;
   logic [31:0] respWord = '0;
   int          respAckAt = 0;
   int          respCnt = 0;
   logic        strayAck = 1'b0;
   int          lowCnt = 0;
   int          reqCnt = 0;

   dmem_access_ctrl #(
      .DATA_W (32),
      .ADDR_W (32),
      .TIMEOUT(4)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .mem_read    (mem_read),
      .mem_write   (mem_write),
      .mem_size    (mem_size),
      .mem_unsigned(mem_unsigned),
      .addr        (addr),
      .wdata       (wdata),
      .mem_ready   (mem_ready),
      .rdata       (rdata),
      .misaligned  (misaligned),
      .bus_err     (bus_err),
      .bus_req     (bus_req),
      .bus_we      (bus_we),
      .bus_addr    (bus_addr),
      .bus_be      (bus_be),
      .bus_wdata   (bus_wdata),
      .bus_ack     (bus_ack),
      .bus_rdata   (bus_rdata)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic exp_t mkExp(input int low, input int req, input logic [31:0] a,
                                  input logic [3:0] be, input logic we, input logic [31:0] wd,
                                  input logic [31:0] rd, input logic err, input logic mis);
      exp_t e;
      e.lowCycles = low;
      e.reqCycles = req;
      e.addr      = a;
      e.be        = be;
      e.we        = we;
      e.wdata     = wd;
      e.rdata     = rd;
      e.err       = err;
      e.mis       = mis;
      return e;
   endfunction

   // Issue one request, then hold it until the controller reports ready.
   task automatic applyStimulus(input logic rd, input logic wr, input logic [1:0] size,
                                input logic uns, input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] word, input int ackAt, input exp_t e);
      bit done;
      expQ.push_back(e);
      respWord     = word;
      respAckAt    = ackAt;
      mem_read     = rd;
      mem_write    = wr;
      mem_size     = size;
      mem_unsigned = uns;
      addr         = a;
      wdata        = wd;
      done         = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clock);
         if (mem_ready) begin
            done = 1'b1;
            break;
         end
      end
      if (!done) checkOutput("completion timeout", 32'(done), 32'd1);
      @(posedge clock);
      #1;
      mem_read  = 1'b0;
      mem_write = 1'b0;
   endtask

   task automatic idleCycles(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   // Memory responder: acks on the requested REQ cycle, or strays while idle.
   initial begin
      bus_ack   = 1'b0;
      bus_rdata = 32'h0;
      forever begin
         @(negedge clock);
         bus_ack = 1'b0;
         if (bus_req) begin
            respCnt++;
            if (respCnt == respAckAt) begin
               bus_ack   = 1'b1;
               bus_rdata = respWord;
            end
         end else begin
            respCnt = 0;
            if (strayAck) begin
               bus_ack   = 1'b1;
               bus_rdata = 32'hBAD0BAD0;
            end
         end
      end
   end

   // Monitor: checks bus fields during REQ and pops the scoreboard on completion.
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (!reset) begin
            lowCnt = 0;
            reqCnt = 0;
         end else if (!(mem_read | mem_write)) begin
            checkOutput("idle mem_ready", 32'(mem_ready), 32'd1);
            checkOutput("idle bus_req", 32'(bus_req), 32'd0);
         end else begin
            if (expQ.size() > 0) begin
               checkOutput("misaligned", 32'(misaligned), 32'(expQ[0].mis));
               if (bus_req) begin
                  checkOutput("bus_addr", bus_addr, expQ[0].addr);
                  checkOutput("bus_be", 32'(bus_be), 32'(expQ[0].be));
                  checkOutput("bus_we", 32'(bus_we), 32'(expQ[0].we));
                  if (expQ[0].we) checkOutput("bus_wdata", bus_wdata, expQ[0].wdata);
               end
            end
            if (bus_req) reqCnt++;
            if (!mem_ready) begin
               lowCnt++;
            end else begin
               if (expQ.size() == 0) begin
                  checkOutput("unexpected completion", 32'(expQ.size()), 32'd1);
               end else begin
                  e = expQ.pop_front();
                  checkOutput("stall cycles", 32'(lowCnt), 32'(e.lowCycles));
                  checkOutput("req cycles", 32'(reqCnt), 32'(e.reqCycles));
                  checkOutput("bus_err", 32'(bus_err), 32'(e.err));
                  if (!e.mis) checkOutput("rdata", rdata, e.rdata);
               end
               lowCnt = 0;
               reqCnt = 0;
            end
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset        = 1'b0;
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      mem_size     = 2'b00;
      mem_unsigned = 1'b0;
      addr         = 32'h0;
      wdata        = 32'h0;
      #12;
      checkOutput("reset bus_req", 32'(bus_req), 32'd0);
      checkOutput("reset mem_ready", 32'(mem_ready), 32'd1);
      checkOutput("reset rdata", rdata, 32'h0);
      checkOutput("reset bus_err", 32'(bus_err), 32'd0);
      checkOutput("reset bus_be", 32'(bus_be), 32'd0);
      checkOutput("reset bus_addr", bus_addr, 32'h0);
      #3 reset = 1'b1;
      idleCycles(2);

      applyStimulus(1, 0, 2'b10, 0, 32'h100, 32'h0, 32'hDEADBEEF, 3,
                    mkExp(4, 3, 32'h100, 4'b1111, 0, 32'h0, 32'hDEADBEEF, 0, 0));
      applyStimulus(1, 0, 2'b10, 0, 32'h300, 32'h0, 32'h11111111, 0,
                    mkExp(6, 5, 32'h300, 4'b1111, 0, 32'h0, 32'h0, 1, 0));
      idleCycles(1);
      applyStimulus(1, 0, 2'b00, 0, 32'h103, 32'h0, 32'h80000000, 1,
                    mkExp(2, 1, 32'h100, 4'b1000, 0, 32'h0, 32'hFFFFFF80, 0, 0));
      applyStimulus(1, 0, 2'b00, 1, 32'h103, 32'h0, 32'h80000000, 1,
                    mkExp(2, 1, 32'h100, 4'b1000, 0, 32'h0, 32'h00000080, 0, 0));
      applyStimulus(1, 0, 2'b01, 0, 32'h002, 32'h0, 32'h80017FFF, 5,
                    mkExp(6, 5, 32'h000, 4'b1100, 0, 32'h0, 32'hFFFF8001, 0, 0));
      applyStimulus(1, 0, 2'b01, 1, 32'h000, 32'h0, 32'h80017FFF, 2,
                    mkExp(3, 2, 32'h000, 4'b0011, 0, 32'h0, 32'h00007FFF, 0, 0));
      applyStimulus(1, 0, 2'b00, 0, 32'h001, 32'h0, 32'h0000C300, 1,
                    mkExp(2, 1, 32'h000, 4'b0010, 0, 32'h0, 32'hFFFFFFC3, 0, 0));
      applyStimulus(1, 1, 2'b00, 0, 32'h001, 32'h0000005A, 32'h77777777, 1,
                    mkExp(2, 1, 32'h000, 4'b0010, 1, 32'h5A5A5A5A, 32'h0, 0, 0));
      strayAck = 1'b1;
      idleCycles(2);
      strayAck = 1'b0;
      applyStimulus(0, 1, 2'b01, 0, 32'h202, 32'h0000ABCD, 32'h12345678, 2,
                    mkExp(3, 2, 32'h200, 4'b1100, 1, 32'hABCDABCD, 32'h0, 0, 0));
      applyStimulus(0, 1, 2'b10, 0, 32'h010, 32'h01234567, 32'h0, 1,
                    mkExp(2, 1, 32'h010, 4'b1111, 1, 32'h01234567, 32'h0, 0, 0));
      applyStimulus(1, 0, 2'b10, 0, 32'h101, 32'h0, 32'h0, 1,
                    mkExp(0, 0, 32'h0, 4'b0000, 0, 32'h0, 32'h0, 0, 1));
      idleCycles(2);
      applyStimulus(1, 0, 2'b01, 0, 32'h203, 32'h0, 32'h0, 1,
                    mkExp(0, 0, 32'h0, 4'b0000, 0, 32'h0, 32'h0, 0, 1));
      applyStimulus(1, 0, 2'b11, 0, 32'h000, 32'h0, 32'h0, 1,
                    mkExp(0, 0, 32'h0, 4'b0000, 0, 32'h0, 32'h0, 0, 1));
      applyStimulus(1, 0, 2'b10, 0, 32'h104, 32'h0, 32'hCAFEF00D, 1,
                    mkExp(2, 1, 32'h104, 4'b1111, 0, 32'h0, 32'hCAFEF00D, 0, 0));
      idleCycles(1);

      // Abandon an access mid-REQ with an asynchronous reset.
      respAckAt = 0;
      mem_read  = 1'b1;
      mem_size  = 2'b10;
      addr      = 32'h400;
      repeat (2) @(negedge clock);
      #2 reset = 1'b0;
      #1;
      checkOutput("async reset bus_req", 32'(bus_req), 32'd0);
      checkOutput("async reset rdata", rdata, 32'h0);
      mem_read = 1'b0;
      repeat (2) @(posedge clock);
      #3 reset = 1'b1;
      idleCycles(3);
      checkOutput("post reset mem_ready", 32'(mem_ready), 32'd1);
      checkOutput("post reset bus_err", 32'(bus_err), 32'd0);
      checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
Data-memory access controller for the MEM stage. It turns the EX/MEM load/store request into a req/ack transaction on the external data bus. It produces the mem_ready signal consumed by the ID-stage stall controller as memReady. While mem_ready is low, that controller freezes PC, IF/ID, ID/EX, EX/MEM and MEM/WB, so the request inputs stay stable for the whole access.

Parameters:
DATA_W, 32, data width; only 32 is supported.
ADDR_W, 32, byte-address width.
TIMEOUT, 255, number of REQ cycles without bus_ack before the access aborts with bus_err; width of the wait counter is clog2(TIMEOUT+1).

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
mem_read  in  1  EX/MEM load request.
mem_write  in  1  EX/MEM store request.
mem_size  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved.
mem_unsigned  in  1  1 = zero-extend loads, 0 = sign-extend loads.
addr  in  ADDR_W  byte address.
wdata  in  DATA_W  store data, right-justified.
mem_ready  out  1  1 = no access pending or access completes this cycle; drives memReady.
rdata  out  DATA_W  extended load data, valid while mem_ready=1 in DONE.
misaligned  out  1  alignment/size fault, combinational, same cycle as the request.
bus_err  out  1  timeout fault, asserted in DONE only.
bus_req  out  1  registered bus request.
bus_we  out  1  registered, 1 = write.
bus_addr  out  ADDR_W  registered, word-aligned address (addr[1:0] forced to 00).
bus_be  out  4  registered byte enables.
bus_wdata  out  DATA_W  registered, lane-replicated store data.
bus_ack  in  1  single-cycle acknowledge from memory.
bus_rdata  in  DATA_W  read word, valid with bus_ack.

Behaviour:
- Reset (async, reset=0): state=IDLE, counter=0, all registered bus outputs 0, rdata register 0, bus_err 0. mem_ready reads 1 while state=IDLE and no request is present.
- Request: access = mem_read|mem_write. If both are 1, the access is a store (bus_we=1).
- Misaligned condition: half with addr[0]=1; word with addr[1:0]!=00; mem_size=11.
- IDLE, access and not misaligned:
  - mem_ready=0 combinationally.
  - Bus outputs load; next state REQ.
- IDLE, access and misaligned:
  - misaligned=1, mem_ready=1, no bus activity.
  - Stays IDLE; the trap path handles the fault.
- IDLE, no access: mem_ready=1.
- REQ:
  - bus_req=1, mem_ready=0, counter increments each cycle.
  - bus_ack=1: capture bus_rdata, drop bus_req at the next edge, go to DONE.
  - counter==TIMEOUT and no ack: go to DONE with bus_err set, captured data forced to 0.
  - Ack on the timeout cycle counts as success.
- DONE:
  - mem_ready=1 for exactly one cycle; rdata is valid; bus_err is held if set.
  - Next state IDLE; counter cleared.
  - The pipeline advances on this edge, so the same access is never reissued.
- Latency: with ack in the first REQ cycle, a request seen in cycle 0 gives mem_ready high in cycle 2 (2 stall cycles). Each extra wait cycle adds 1.
- Byte enables (little-endian):
  - Byte: be = 0001 shifted left by addr[1:0].
  - Half: addr[1]=0 gives 0011; addr[1]=1 gives 1100.
  - Word: 1111.
- wdata lanes: byte is replicated x4; half is replicated x2; word passes through.
- Load extraction: select the lane by addr[1:0], then sign- or zero-extend per mem_unsigned. For stores, rdata is 0.
- Bus outputs are held constant from REQ entry until DONE.
- bus_ack in IDLE or DONE is ignored.
- Reset mid-access: bus_req drops asynchronously; the in-flight transaction is abandoned.

Decomposition:
- Shared package/header holds:
  - MEM_SIZE_BYTE/HALF/WORD encodings.
  - FSM state encodings IDLE/REQ/DONE.
  - DEFAULT_TIMEOUT.
- Sub-module dmem_lane_align (combinational): generates bus_be, replicates wdata, extracts/extends load data, flags misalignment.
- The FSM, counter and registers stay in dmem_access_ctrl.

Test Plan:
- Word load at addr 0x100, bus_rdata=0xDEADBEEF, ack after 3 REQ cycles -> bus_be=1111, bus_addr=0x100, mem_ready low 4 cycles then high 1 cycle, rdata=0xDEADBEEF.
- Signed byte load at addr 0x103, bus_rdata=0x80000000 -> bus_be=1000, rdata=0xFFFFFF80; repeat with mem_unsigned=1 -> rdata=0x00000080.
- Half store at addr 0x202, wdata=0x0000ABCD -> bus_we=1, bus_be=1100, bus_wdata=0xABCDABCD; rdata=0 in DONE.
- Word load at addr 0x101 -> misaligned=1, mem_ready=1, bus_req stays 0 for all cycles.
- No ack with TIMEOUT=4 -> bus_req high 5 cycles, then DONE with bus_err=1, rdata=0, mem_ready=1.
- reset driven low during REQ -> bus_req=0 immediately; after release, state IDLE and mem_ready=1 with no request.
